// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    // Instruction returned for out-of-range fetches.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Number of fetched words the prefetch buffer can hold.
    localparam int unsigned FIFO_DEPTH = 2;

    // One prefetch buffer entry: the instruction word tagged with its byte address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry prefetch FIFO of fetch_entry_t with push, pop and flush.
// The head entry is a register that keeps its last value after the FIFO
// drains, so downstream sees a stable word even when nothing is valid.
// Flush takes priority over push and pop in the same cycle.
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o
);

    fetch_entry_t head_q, head_d;
    fetch_entry_t tail_q, tail_d;
    logic [1:0]   count_q, count_d;

    // Next-state for the two entry registers and the occupancy count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d  = push_data_i;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_d  = push_data_i;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        count_d = 2'd0;
                    end
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end else begin
                        head_d  = push_data_i;
                        count_d = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Entry and count registers, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, synchronous-read instruction memory,
// one-deep in-flight read tracking and a two-entry prefetch FIFO.
// Handshake: a {instr_pc, instr} pair transfers on a rising edge where
// instr_valid and instr_ready are both high and redirect_valid is low;
// instr_valid never depends on instr_ready.
// Optional macro IFETCH_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    input  logic                          instr_ready,
    output logic                          instr_valid,
    output logic [31:0]                   instr,
    output logic [31:0]                   instr_pc,
    output logic [31:0]                   pc_plus4,
    output logic                          fetch_fault
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_flushed
`endif
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0]  mem [IMEM_DEPTH];
    logic [31:0]  rdata_q;
    logic [31:0]  fpc_q, fpc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         fault_q, fault_d;

    logic         pop;
    logic         push;
    logic         issue;
    logic         addr_oor;
    logic [2:0]   occupancy;
    logic [1:0]   fifo_count;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;

    // A redirect suppresses the pop; the FIFO flush also drops the returning word.
    assign pop        = instr_valid & instr_ready & ~redirect_valid;
    assign push       = inflight_q & ~redirect_valid;
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (occupancy < 3'd2) & ~redirect_valid;
    assign addr_oor   = ({2'b00, fpc_q[31:2]} >= 32'(IMEM_DEPTH));
    assign push_entry = '{pc: inflight_pc_q, instr: rdata_q};

    // Next-state for fetch PC, in-flight tag and sticky fault; redirect wins.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        fault_d       = fault_q;
        if (redirect_valid) begin
            fpc_d      = {redirect_pc[31:2], 2'b00};
            inflight_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
            end
        end else begin
            inflight_d = issue;
            if (issue) begin
                fpc_d         = fpc_q + 32'd4;
                inflight_pc_d = fpc_q;
                if (addr_oor) begin
                    fault_d = 1'b1;
                end
            end
        end
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            fault_q       <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            fault_q       <= fault_d;
        end
    end

    // Instruction memory: preload write port and synchronous read (old data on collision).
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
        if (issue) begin
            rdata_q <= addr_oor ? NOP_INSTR : mem[fpc_q[AW+1:2]];
        end
    end

    ifetch_fifo u_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign instr_valid = (fifo_count != 2'd0);
    assign instr       = fifo_head.instr;
    assign instr_pc    = fifo_head.pc;
    assign pc_plus4    = fifo_head.pc + 32'd4;
    assign fetch_fault = fault_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    // Wrapping counters of accepted handshakes and of words discarded by redirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= 32'h0;
            perf_flushed_q <= 32'h0;
        end else begin
            perf_fetched_q <= perf_fetched_q + {31'h0, pop};
            if (redirect_valid) begin
                perf_flushed_q <= perf_flushed_q + {30'h0, fifo_count} + {31'h0, inflight_q};
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of `SimpleMIPSCPU`; it drives the CPU `instruction` input, replacing the bench-driven instruction array. It holds the fetch PC and a synchronous-read instruction memory, and buffers fetched words in a 2-entry prefetch FIFO. It delivers `{pc, instruction}` pairs over a valid/ready handshake and is flushed by branch/jump redirects from the execute side. A write port allows the bench to preload the program before execution.

## Interface
- `IMEM_DEPTH`, 64: instruction memory size in 32-bit words (power of two).
- `RESET_PC`, 32'h0000_0000: fetch address after reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `imem_we` in 1: preload write enable.
- `imem_waddr` in $clog2(IMEM_DEPTH): preload word address.
- `imem_wdata` in 32: preload data.
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch byte address.
- `instr_ready` in 1: downstream accepts the head entry.
- `instr_valid` out 1: head entry valid.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: byte address of `instr`.
- `pc_plus4` out 32: `instr_pc + 4`, modulo 2^32.
- `fetch_fault` out 1: sticky flag for an out-of-range or misaligned fetch.

## Operation
- Reset values: `fpc`=RESET_PC; FIFO empty; no read in flight; `instr_valid`=0; `instr`=0; `instr_pc`=0; `pc_plus4`=4; `fetch_fault`=0. Memory contents are not cleared by reset.
- Occupancy = FIFO count + in-flight read − pop, where pop = `instr_valid && instr_ready`.
- A read is issued at `fpc` when occupancy < 2 and `redirect_valid`=0. On issue, `fpc` advances by 4 with 32-bit wrap.
- Read data returns one cycle after issue and is pushed into the FIFO tagged with its PC, in that same cycle.
- Word address is `fpc[31:2]`. If the word address ≥ IMEM_DEPTH, the read returns NOP (32'h0) and sets `fetch_fault`.
- Redirect handling:
  - `redirect_valid` has priority over every other event in the same cycle.
  - It empties the FIFO, discards any in-flight read, and suppresses any pop that cycle.
  - `fpc` is loaded with `{redirect_pc[31:2],2'b00}`.
  - If `redirect_pc[1:0]`≠0, `fetch_fault` is set.
- `fetch_fault` clears only on `rst`.
- Preload write:
  - A preload write to the address being read in the same cycle returns the old data.
  - Preloading while fetching is legal but is intended only while `rst`=1.
- Outputs are driven directly from the FIFO head register. When the FIFO is empty, `instr` holds its last value.

## Timing
- Issue-to-valid latency is 2 cycles. With `rst` low in cycle 0, RESET_PC is issued in cycle 0, data returns in cycle 1, and `instr_valid`=1 in cycle 2.
- Redirect in cycle N: target issued in N+1, valid in N+3.
- With `instr_ready` held high and no redirects, throughput is one instruction per cycle after the first.
- `instr_ready`=0 holds the head stable. Fetch stops once occupancy reaches 2, so there is no overflow.
- Asserting `rst` mid-operation returns the block to reset values on the next edge, regardless of redirect or preload activity.

## Configuration
- `IFETCH_PERF_CNT_EN` defined:
  - Adds output `perf_fetched` [31:0], counting accepted handshakes.
  - Adds output `perf_flushed` [31:0], counting entries plus in-flight reads discarded by redirects.
  - Both counters reset to 0 and wrap.
- `IFETCH_PERF_CNT_EN` undefined: both ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `ifetch_pkg`:
  - `NOP_INSTR` = 32'h0.
  - `fetch_entry_t` = {pc[31:0], instr[31:0]}.
  - FIFO depth constant = 2.
- Sub-module `ifetch_fifo`: 2-entry FIFO of `fetch_entry_t` with push/pop/flush and a count output.
- The top level holds `fpc`, the memory array, in-flight tracking, and fault logic.

## Test plan
- Preload words 0..3 = 32'h2001_0005, 32'h2002_000A, 32'h0022_1820, 32'hAC03_0000; release `rst` with `instr_ready`=1 → `instr_valid` rises in cycle 2; pairs (0,2001_0005), (4,2002_000A), (8,0022_1820), (C,AC03_0000) follow on consecutive cycles.
- Hold `instr_ready`=0 for 5 cycles after the first valid → `instr_pc` stays 0; exactly 2 entries are buffered; on release, PCs 0, 4, 8 appear with no gap or duplicate.
- `redirect_valid` with `redirect_pc`=32'h0000_0010 while the FIFO is full → the next valid, 3 cycles later, is `instr_pc`=0x10; no stale 0x4/0x8 is delivered.
- Redirect and `instr_ready`=1 in the same cycle → no handshake is counted; with `IFETCH_PERF_CNT_EN`, `perf_flushed` increases by the discarded count.
- `redirect_pc`=32'h0000_0102 → fetch from 0x100, which is out of range for IMEM_DEPTH=64 → `instr`=0, `fetch_fault`=1 and it stays 1 until `rst`.
